sat_accumulator: RTL and testbench
==================================

Name: sat_accumulator

Overview:
Sequential consumer stage for the saturating `adder`. It accepts a stream of signed DATAW-bit terms over a valid/ready handshake and folds each group of NUM_TERMS terms into one saturated sum. The sum is presented on a valid/ready output port. This is the reduction stage that feeds local-field / energy partial sums to downstream logic.

Parameters:
- DATAW, 8, signed data width of terms, accumulator and result.
- NUM_TERMS, 4, terms per group; must be >= 1 (elaboration-time $error otherwise).
- CNTW, $clog2(NUM_TERMS)+1, localparam width of the term counter; not overridable.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- in_data_i  in  DATAW  signed input term.
- in_valid_i  in  1  in_data_i valid.
- in_ready_o  out  1  block can accept a term this cycle.
- out_data_o  out  DATAW  signed saturated group sum.
- out_valid_o  out  1  out_data_o valid.
- out_ready_i  in  1  downstream accepts out_data_o.
- busy_o  out  1  high when at least one term of the current group has been accepted, or a result is pending.

Behaviour:
- Reset (rst_i=1 at clk_i edge), highest priority, also mid-group or mid-output:
  - state<=ACC, cnt<=0, acc<=0, out_data_o<=0, out_valid_o<=0.
  - Any partial group or pending result is discarded.
- State ACC:
  - in_ready_o=1, out_valid_o=0.
  - Term accepted when in_valid_i && in_ready_o.
  - On acceptance: acc <= sat(acc + in_data_i), cnt<=cnt+1.
  - No acceptance: acc and cnt hold (bubbles allowed at any point).
- Group completion: the term accepted while cnt==NUM_TERMS-1.
  - out_data_o <= sat(acc + in_data_i), out_valid_o<=1, acc<=0, cnt<=0, state<=OUT.
  - Latency: result valid exactly 1 cycle after the last term is accepted.
- State OUT:
  - in_ready_o=0; in_valid_i is ignored.
  - out_data_o and out_valid_o hold stable until out_ready_i=1.
  - On out_valid_o && out_ready_i: out_valid_o<=0, state<=ACC. The next term can be accepted in the following cycle.
  - No overlap between result holding and term acceptance.
  - Minimum period is NUM_TERMS+1 cycles per group.
- sat():
  - Computed by the `adder` instance on (acc, in_data_i).
  - Result clamps to [-2^(DATAW-1), 2^(DATAW-1)-1]. For DATAW=8 this is [-128, 127].
  - Saturation is per partial sum and not sticky: 127 + (-1) = 126. Group results are therefore order-dependent.
- NUM_TERMS=1: every accepted term goes straight to OUT with out_data_o = in_data_i. acc stays 0.
- busy_o = (cnt != 0) || (state == OUT). Combinational, 0 after reset.
- in_ready_o is combinational from state only, with no dependency on in_valid_i. out_valid_o is registered.

Optional Feature:
- Macro: SAT_ACCUMULATOR_OVF_FLAG_EN.
- Defined:
  - Adds port ovf_o (out, 1).
  - ovf_o is registered alongside out_data_o and valid only while out_valid_o=1.
  - It is high if any partial sum in the group clamped, i.e. the true sum of acc + term was outside range.
  - The internal sticky bit clears on group completion and on reset. ovf_o resets to 0.
- Undefined: port and logic absent. Behaviour is otherwise identical.

Decomposition:
- Shared package sat_acc_pkg:
  - typedef enum logic {ACC, OUT} sat_acc_state_e.
  - Functions/constants sat_max(DATAW) / sat_min(DATAW), for bench reference models.
- Sub-module: instantiate the existing `adder` (DATAW) as the single combinational saturating adder. No new sub-module.

Test Plan (DATAW=8, NUM_TERMS=4, out_ready_i=1 unless noted):
- Terms 1,2,3,4 back-to-back -> out_data_o=10, out_valid_o high exactly 1 cycle after 4th acceptance, for 1 cycle; in_ready_o=0 that cycle.
- Terms 100,100,-50,-50 -> partials 100,127,77,27 -> out_data_o=27. With OVF_FLAG_EN: ovf_o=1. Next group 1,1,1,1 -> 4, ovf_o=0.
- Terms -127,-2,0,0 -> out_data_o=-128. Terms -128,-1,127,0 -> partials -128,-128,-1,-1 -> -1.
- Backpressure:
  - Group 5,5,5,5 with out_ready_i=0 for 6 cycles and in_valid_i=1 with data 9 throughout -> out_data_o=20 stable and in_ready_o=0 for all 6 cycles; no term consumed.
  - After out_ready_i=1 handshake, next accepted term is 9.
- Bubbles: 3,_,_,4,_,-2,1 (in_valid_i low on _) -> out_data_o=6; busy_o high from after 1st acceptance until output handshake.
- rst_i pulsed 1 cycle after terms 50,50 -> out_valid_o=0, busy_o=0. Then terms 1,1,1,1 -> out_data_o=4, with no residue from the discarded partial.

Source files
------------

// File: rtl/sat_accumulator_pkg.sv
// Shared types and saturation bounds for sat_accumulator.
package sat_acc_pkg;

    typedef enum logic {ACC, OUT} sat_acc_state_e;

    function automatic int sat_max(input int dataw);
        return (1 << (dataw - 1)) - 1;
    endfunction

    function automatic int sat_min(input int dataw);
        return -(1 << (dataw - 1));
    endfunction

endpackage

// File: rtl/sat_accumulator_adder.sv
// Combinational signed saturating adder; ovf flags a clamped result.
module adder #(
    parameter int DATAW = 8
) (
    input  logic [DATAW-1:0] a,
    input  logic [DATAW-1:0] b,
    output logic [DATAW-1:0] sum,
    output logic             ovf
);

    logic [DATAW:0] full;

    always_comb begin
        full = {a[DATAW-1], a} + {b[DATAW-1], b};
        // Sign bits of the extended sum disagree only when the true sum is out of range.
        ovf  = full[DATAW] ^ full[DATAW-1];
        if (!ovf)
            sum = full[DATAW-1:0];
        else if (full[DATAW])
            sum = {1'b1, {(DATAW-1){1'b0}}};
        else
            sum = {1'b0, {(DATAW-1){1'b1}}};
    end

endmodule

// File: rtl/sat_accumulator.sv
// Folds each group of NUM_TERMS signed terms into one saturated sum.
// Optional SAT_ACCUMULATOR_OVF_FLAG_EN adds ovf_o, set when any partial sum clamped.
module sat_accumulator
    import sat_acc_pkg::*;
#(
    parameter int DATAW     = 8,
    parameter int NUM_TERMS = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DATAW-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [DATAW-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
`ifdef SAT_ACCUMULATOR_OVF_FLAG_EN
    output logic             ovf_o,
`endif
    output logic             busy_o
);

    localparam int CNTW = $clog2(NUM_TERMS) + 1;

    if (NUM_TERMS < 1) begin : g_bad_num_terms
        $error("sat_accumulator: NUM_TERMS must be >= 1");
    end

    sat_acc_state_e   state, state_n;
    logic [CNTW-1:0]  cnt;
    logic [DATAW-1:0] acc;
    logic [DATAW-1:0] sum;
    logic             sum_ovf;
    logic             accept;
    logic             last;

    adder #(.DATAW(DATAW)) u_adder (
        .a   (acc),
        .b   (in_data_i),
        .sum (sum),
        .ovf (sum_ovf)
    );

    assign accept = in_valid_i && in_ready_o;
    assign last   = (cnt == CNTW'(NUM_TERMS - 1));
    assign busy_o = (cnt != '0) || (state == OUT);

    always_comb begin
        state_n    = state;
        in_ready_o = 1'b0;
        case (state)
            ACC: begin
                in_ready_o = 1'b1;
                if (accept && last)
                    state_n = OUT;
            end
            OUT: begin
                if (out_valid_o && out_ready_i)
                    state_n = ACC;
            end
            default: state_n = ACC;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ACC;
            cnt         <= '0;
            acc         <= '0;
            out_data_o  <= '0;
            out_valid_o <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                if (last) begin
                    out_data_o  <= sum;
                    out_valid_o <= 1'b1;
                    acc         <= '0;
                    cnt         <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CNTW'(1);
                end
            end
            if (state == OUT && out_ready_i)
                out_valid_o <= 1'b0;
        end
    end

`ifdef SAT_ACCUMULATOR_OVF_FLAG_EN
    logic sticky;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky <= 1'b0;
            ovf_o  <= 1'b0;
        end else begin
            if (accept) begin
                if (last) begin
                    ovf_o  <= sticky | sum_ovf;
                    sticky <= 1'b0;
                end else begin
                    sticky <= sticky | sum_ovf;
                end
            end
            if (state == OUT && out_ready_i)
                ovf_o <= 1'b0;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = sum_ovf;
`endif

endmodule

// File: tb/tb_sat_accumulator.sv
// Scoreboard bench for sat_accumulator (DATAW=8, NUM_TERMS=4).
module tb_sat_accumulator;
    import sat_acc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
`ifdef SAT_ACCUMULATOR_OVF_FLAG_EN
    logic       ovf;
`endif

    int tests  = 0;
    int fails  = 0;
    logic [8:0] expq[$];   // {ovf, data}

    always #5 clk = ~clk;

    sat_accumulator #(.DATAW(8), .NUM_TERMS(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
`ifdef SAT_ACCUMULATOR_OVF_FLAG_EN
        .ovf_o       (ovf),
`endif
        .busy_o      (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input int data, input logic ovf_exp);
        logic [7:0] d;
        d = data[7:0];
        expq.push_back({ovf_exp, d});
    endtask

    task automatic send(input int d);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d[7:0];
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
        end
        if (!done) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every output handshake against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    logic [8:0] e;
                    e = expq.pop_front();
                    check("out_data", $signed(out_data), $signed(e[7:0]));
`ifdef SAT_ACCUMULATOR_OVF_FLAG_EN
                    check("ovf", int'(ovf), int'(e[8]));
`endif
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        idle(2);
        rst = 1'b0;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("sat_max", sat_max(8), 127);
        check("sat_min", sat_min(8), -128);

        // 1,2,3,4 -> 10, one-cycle latency and one-cycle valid
        expect_out(10, 1'b0);
        send(1); send(2); send(3); send(4);
        check("lat_valid", int'(out_valid), 1);
        check("lat_in_ready", int'(in_ready), 0);
        idle(1);
        check("valid_one_cycle", int'(out_valid), 0);

        // clamped partial, not sticky
        expect_out(27, 1'b1);
        send(100); send(100); send(-50); send(-50);
        idle(1);
        expect_out(4, 1'b0);
        send(1); send(1); send(1); send(1);
        idle(1);

        // negative bound
        expect_out(-128, 1'b1);
        send(-127); send(-2); send(0); send(0);
        idle(1);
        expect_out(-1, 1'b1);
        send(-128); send(-1); send(127); send(0);
        idle(1);

        // backpressure: result holds, 9 must not be consumed
        out_ready = 1'b0;
        expect_out(20, 1'b0);
        send(5); send(5); send(5); send(5);
        in_valid = 1'b1; in_data = 8'd9;
        for (int i = 0; i < 6; i++) begin
            check("bp_valid", int'(out_valid), 1);
            check("bp_data", $signed(out_data), 20);
            check("bp_in_ready", int'(in_ready), 0);
            idle(1);
        end
        out_ready = 1'b1;
        idle(1);
        expect_out(12, 1'b0);
        send(9); send(1); send(1); send(1);
        idle(1);

        // bubbles
        check("busy_idle", int'(busy), 0);
        expect_out(6, 1'b0);
        send(3);
        check("busy_after_first", int'(busy), 1);
        idle(2);
        check("busy_bubble", int'(busy), 1);
        send(4);
        idle(1);
        send(-2);
        send(1);
        check("busy_pending", int'(busy), 1);
        idle(1);
        check("busy_after_hs", int'(busy), 0);

        // reset discards partial group
        send(50); send(50);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_busy", int'(busy), 0);
        expect_out(4, 1'b0);
        send(1); send(1); send(1); send(1);
        idle(3);

        check("scoreboard_empty", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
